// File: rtl/corr_accum.sv
// Integrate-and-dump correlator: wipes 1-bit IF samples with LO and C/A code,
// accumulates saturating signed I/Q sums and presents each dump on valid/ready.
module corr_accum #(
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned DUMP_LEN = 4000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sample_en,
    input  logic             if_sign,
    input  logic             lo_sin,
    input  logic             lo_cos,
    input  logic             code,
    input  logic             epoch,
    output logic [ACC_W-1:0] i_dump,
    output logic [ACC_W-1:0] q_dump,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic             overrun,
    output logic             running
);

    localparam int unsigned STEP_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_LEN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] i_acc, q_acc;
    logic             i_sat, q_sat;

    logic             pi, pq;
    logic             accept, dump_evt;
    logic [CNT_W-1:0] base_cnt;
    logic [ACC_W-1:0] base_i, base_q;
    logic             base_i_sat, base_q_sat;
    logic [ACC_W:0]   i_next, q_next;

    // One +/-1 accumulation step; MSB of the result is the sticky clamp flag.
    function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] base,
                                                input logic sat, input logic p);
        logic [STEP_W-1:0] sum;
        if (sat) begin
            return {1'b1, base};
        end
        sum = {base[ACC_W-1], base} + (p ? STEP_W'(1) : {STEP_W{1'b1}});
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return {1'b1, (sum[ACC_W] ? ACC_MIN : ACC_MAX)};
        end
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    // The epoch sample starting a run is accumulated from a zero base.
    always_comb begin
        pi         = if_sign ~^ lo_cos ~^ code;
        pq         = if_sign ~^ lo_sin ~^ code;
        accept     = enable & sample_en & ((state == RUN) | epoch);
        base_cnt   = (state == RUN) ? cnt   : '0;
        base_i     = (state == RUN) ? i_acc : '0;
        base_q     = (state == RUN) ? q_acc : '0;
        base_i_sat = (state == RUN) & i_sat;
        base_q_sat = (state == RUN) & q_sat;
        dump_evt   = accept & (base_cnt == CNT_LAST);
        i_next     = acc_step(base_i, base_i_sat, pi);
        q_next     = acc_step(base_q, base_q_sat, pq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            i_acc      <= '0;
            q_acc      <= '0;
            i_sat      <= 1'b0;
            q_sat      <= 1'b0;
            i_dump     <= '0;
            q_dump     <= '0;
            dump_valid <= 1'b0;
            overrun    <= 1'b0;
            running    <= 1'b0;
        end else begin
            if (dump_valid && dump_ready) begin
                dump_valid <= 1'b0;
            end
            if (!enable) begin
                state   <= IDLE;
                running <= 1'b0;
                cnt     <= '0;
                i_acc   <= '0;
                q_acc   <= '0;
                i_sat   <= 1'b0;
                q_sat   <= 1'b0;
            end else if (accept) begin
                state   <= RUN;
                running <= 1'b1;
                if (dump_evt) begin
                    i_dump     <= i_next[ACC_W-1:0];
                    q_dump     <= q_next[ACC_W-1:0];
                    dump_valid <= 1'b1;
                    if (dump_valid && !dump_ready) begin
                        overrun <= 1'b1;
                    end
                    cnt   <= '0;
                    i_acc <= '0;
                    q_acc <= '0;
                    i_sat <= 1'b0;
                    q_sat <= 1'b0;
                end else begin
                    cnt   <= base_cnt + CNT_W'(1);
                    i_acc <= i_next[ACC_W-1:0];
                    q_acc <= q_next[ACC_W-1:0];
                    i_sat <= i_next[ACC_W];
                    q_sat <= q_next[ACC_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_corr_accum.sv
// Directed bench for corr_accum: a +/-1 product model pushes expected dumps to a
// scoreboard; a second instance (ACC_W=8, DUMP_LEN=300) exercises saturation.
module tb_corr_accum;

    localparam int DLEN = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0, sample_en = 1'b0, if_sign = 1'b0, lo_sin = 1'b0;
    logic lo_cos = 1'b0, code = 1'b0, epoch = 1'b0, dump_ready = 1'b0;
    logic ready2 = 1'b1;

    logic signed [15:0] i_dump, q_dump;
    logic               dump_valid, overrun, running;
    logic signed [7:0]  i_dump2, q_dump2;
    logic               dump_valid2, overrun2, running2;

    always #5 clk = ~clk;

    corr_accum #(.ACC_W(16), .DUMP_LEN(DLEN), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_en(sample_en),
        .if_sign(if_sign), .lo_sin(lo_sin), .lo_cos(lo_cos), .code(code),
        .epoch(epoch), .i_dump(i_dump), .q_dump(q_dump), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .overrun(overrun), .running(running)
    );

    corr_accum #(.ACC_W(8), .DUMP_LEN(300), .CNT_W(16)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_en(sample_en),
        .if_sign(if_sign), .lo_sin(lo_sin), .lo_cos(lo_cos), .code(code),
        .epoch(epoch), .i_dump(i_dump2), .q_dump(q_dump2), .dump_valid(dump_valid2),
        .dump_ready(ready2), .overrun(overrun2), .running(running2)
    );

    typedef struct {
        int i;
        int q;
    } dump_t;

    dump_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    pend     = 1'b0;
    bit    m_run    = 1'b0;
    int    m_i = 0, m_q = 0, m_cnt = 0;

    function automatic int sgn(input logic b);
        return b ? 1 : -1;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one cycle at the falling edge; first score any dump from the previous cycle.
    task automatic send(input logic en, input logic se, input logic ifs, input logic sn,
                        input logic cs, input logic cd, input logic ep, input logic rdy);
        dump_t e;
        @(negedge clk);
        if (pend) begin
            pend = 1'b0;
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'sd1, 32'sd0);
            end else begin
                e = sb.pop_front();
                check("i_dump", 32'(i_dump), e.i);
                check("q_dump", 32'(q_dump), e.q);
                check("dump_valid_set", 32'(dump_valid), 32'sd1);
            end
        end
        enable = en; sample_en = se; if_sign = ifs; lo_sin = sn;
        lo_cos = cs; code = cd; epoch = ep; dump_ready = rdy;
        if (!en) begin
            m_run = 1'b0; m_i = 0; m_q = 0; m_cnt = 0;
        end else if (se) begin
            if (!m_run && ep) begin
                m_run = 1'b1; m_i = 0; m_q = 0; m_cnt = 0;
            end
            if (m_run) begin
                m_i += sgn(ifs) * sgn(cs) * sgn(cd);
                m_q += sgn(ifs) * sgn(sn) * sgn(cd);
                m_cnt++;
                if (m_cnt == DLEN) begin
                    sb.push_back('{m_i, m_q});
                    pend = 1'b1;
                    m_i = 0; m_q = 0; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic idle(input logic en, input logic rdy);
        send(en, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, rdy);
    endtask

    // mode 0: all ones, 1: lo_sin toggles from 1, 2: if_sign low, 3: random bits
    task automatic run(input int n, input int mode, input bit first_epoch, input logic rdy);
        logic ifs, sn, cs, cd;
        for (int k = 0; k < n; k++) begin
            ifs = 1'b1; sn = 1'b1; cs = 1'b1; cd = 1'b1;
            case (mode)
                1: sn = (k % 2 == 0);
                2: ifs = 1'b0;
                3: begin
                    ifs = 1'($urandom); sn = 1'($urandom);
                    cs = 1'($urandom); cd = 1'($urandom);
                end
                default: ;
            endcase
            send(1'b1, 1'b1, ifs, sn, cs, cd, first_epoch && (k == 0), rdy);
        end
    endtask

    task automatic accept_dump();
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        check("dump_valid_cleared", 32'(dump_valid), 32'sd0);
    endtask

    initial begin
        #12;
        check("rst_i_dump", 32'(i_dump), 32'sd0);
        check("rst_q_dump", 32'(q_dump), 32'sd0);
        check("rst_dump_valid", 32'(dump_valid), 32'sd0);
        check("rst_overrun", 32'(overrun), 32'sd0);
        check("rst_running", 32'(running), 32'sd0);
        rst_n = 1'b1;

        // all +1, running rises on the edge capturing the epoch sample
        idle(1'b1, 1'b0);
        run(1, 0, 1'b1, 1'b0);
        check("running_before_edge", 32'(running), 32'sd0);
        run(1, 0, 1'b0, 1'b0);
        check("running_after_epoch", 32'(running), 32'sd1);
        run(DLEN - 2, 0, 1'b0, 1'b0);
        accept_dump();
        check("sat_pos_i", 32'(i_dump2), 32'sd127);

        run(DLEN, 1, 1'b0, 1'b0);
        accept_dump();
        run(DLEN, 2, 1'b0, 1'b0);
        accept_dump();
        check("sat_neg_i", 32'(i_dump2), -32'sd128);

        // samples before the epoch are ignored in IDLE
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("idle_running", 32'(running), 32'sd0);
        send(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        check("no_epoch_running", 32'(running), 32'sd0);
        run(DLEN, 3, 1'b1, 1'b0);
        accept_dump();

        // two unaccepted dumps, then acceptance coincident with a third dump
        run(DLEN, 0, 1'b0, 1'b0);
        run(DLEN, 2, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        check("overrun_set", 32'(overrun), 32'sd1);
        check("overrun_valid", 32'(dump_valid), 32'sd1);
        run(DLEN - 1, 3, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 1'b0);
        check("coincident_valid", 32'(dump_valid), 32'sd1);
        check("overrun_sticky", 32'(overrun), 32'sd1);
        accept_dump();

        // enable dropped mid-run discards the partial sum
        run(DLEN / 2, 0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("partial_no_dump", 32'(dump_valid), 32'sd0);
        check("partial_running", 32'(running), 32'sd0);
        run(DLEN, 1, 1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // asynchronous reset mid-run with a dump still held
        run(100, 0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_i_dump", 32'(i_dump), 32'sd0);
        check("arst_q_dump", 32'(q_dump), 32'sd0);
        check("arst_dump_valid", 32'(dump_valid), 32'sd0);
        check("arst_overrun", 32'(overrun), 32'sd0);
        check("arst_running", 32'(running), 32'sd0);
        check("arst_sat_i_dump", 32'(i_dump2), 32'sd0);
        check("sb_drained", 32'(sb.size()), 32'sd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
